wb_router: RTL and testbench

Parametrised write-back router that takes each result word from the ALU, tagged with a destination index, and delivers it to exactly one of NUM_DEST destination lanes (lane 0 = GPR, 1 = RAM, 2 = PC by default) over valid/ready handshakes. Results are buffered in an in-order FIFO of DEPTH entries so a stalled destination does not drop ALU output. Illegal destination tags are recorded in a sticky error flag. The block sits between the ALU output bus and the register file, data memory and program counter write ports. It replaces the single-cycle combinational output mux.

---
 rtl/wb_router_if.sv | 28 ++
 rtl/wb_router.sv | 102 ++++++++++
 tb/tb_wb_router.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_router_if.sv
// rtl/wb_router_if.sv - handshake bundle between the ALU result bus and the write-back lanes
// Ports (signals):
//   in_valid/in_ready/in_data/in_dest : ALU result offer with destination tag
//   dest_valid/dest_ready/dest_data   : one-hot lane handshakes, lane k at [k*WIDTH +: WIDTH]
// Modports: master = ALU/lane side (testbench), slave = router.
interface wb_router_if #(
   parameter int WIDTH    = 32,
   parameter int NUM_DEST = 3,
   parameter int DW       = $clog2(NUM_DEST)
);
   logic                      in_valid;
   logic                      in_ready;
   logic [WIDTH-1:0]          in_data;
   logic [DW-1:0]             in_dest;
   logic [NUM_DEST-1:0]       dest_valid;
   logic [NUM_DEST-1:0]       dest_ready;
   logic [NUM_DEST*WIDTH-1:0] dest_data;

   modport master (
      output in_valid, in_data, in_dest, dest_ready,
      input  in_ready, dest_valid, dest_data
   );

   modport slave (
      input  in_valid, in_data, in_dest, dest_ready,
      output in_ready, dest_valid, dest_data
   );
endinterface

// File: rtl/wb_router.sv
// rtl/wb_router.sv - in-order FIFO write-back router delivering ALU results to one of NUM_DEST lanes
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   flush    : synchronous discard of all buffered entries (err_dest kept)
//   bus      : wb_router_if slave (ALU input handshake + per-lane output handshakes)
//   count    : number of occupied FIFO entries
//   err_dest : sticky flag, set when an out-of-range tag is accepted
module wb_router #(
   parameter int WIDTH    = 32,
   parameter int NUM_DEST = 3,
   parameter int DEPTH    = 4,
   parameter int DW       = $clog2(NUM_DEST)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   wb_router_if.slave               bus,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err_dest
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0]    data_mem [DEPTH];
   logic [DW-1:0]       tag_mem  [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       cnt;
   logic                err;

   logic                full;
   logic                empty;
   logic                push;
   logic                pop;
   logic                legal;
   logic [DW-1:0]       head_tag;
   logic [NUM_DEST-1:0]       valid_out;
   logic [NUM_DEST*WIDTH-1:0] data_out;

   assign full     = (cnt == CW'(DEPTH));
   assign empty    = (cnt == '0);
   assign head_tag = tag_mem[rd_ptr];
   assign legal    = (32'(bus.in_dest) < 32'(NUM_DEST));

   // in_ready comes from registered count only, so a same-cycle pop cannot reopen a full FIFO.
   assign push = bus.in_valid && !full;
   // Only the head's own lane ready matters; other lanes cannot overtake.
   assign pop  = !empty && bus.dest_ready[head_tag];

   always_comb begin
      valid_out = '0;
      data_out  = '0;
      if (!empty) begin
         valid_out[head_tag]                 = 1'b1;
         data_out[head_tag*WIDTH +: WIDTH]   = data_mem[rd_ptr];
      end
   end

   assign bus.in_ready   = !full;
   assign bus.dest_valid = valid_out;
   assign bus.dest_data  = data_out;
   assign count          = cnt;
   assign err_dest       = err;

   // Storage needs no reset: contents are only observed through count.
   always_ff @(posedge clk) begin
      if (!rst && !flush && push) begin
         data_mem[wr_ptr] <= bus.in_data;
         tag_mem[wr_ptr]  <= legal ? bus.in_dest : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         err    <= 1'b0;
      end else if (flush) begin
         // A push offered this cycle is dropped, so it cannot raise err either.
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (!legal) begin
               err <= 1'b1;
            end
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_router.sv
// tb/tb_wb_router.sv - randomized and directed self-checking bench for wb_router against a queue model
module tb_wb_router;
   localparam int WIDTH    = 32;
   localparam int NUM_DEST = 3;
   localparam int DEPTH    = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic [2:0] count;
   logic       err_dest;

   always #5 clk = ~clk;

   wb_router_if #(.WIDTH(WIDTH), .NUM_DEST(NUM_DEST)) bus ();

   wb_router #(.WIDTH(WIDTH), .NUM_DEST(NUM_DEST), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .bus      (bus.slave),
      .count    (count),
      .err_dest (err_dest)
   );

   typedef struct {
      int          lane;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   logic        merr;
   logic [31:0] dut_out[$];
   logic [31:0] sent[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at the negedge with inputs already driven: checks outputs against the model,
   // advances the model by one clock edge, then moves to the next negedge.
   task automatic step();
      logic [NUM_DEST-1:0]       ev;
      logic [NUM_DEST*WIDTH-1:0] ed;
      bit                        do_push;
      bit                        do_pop;
      ev = '0;
      ed = '0;
      if (mq.size() > 0) begin
         ev[mq[0].lane]           = 1'b1;
         ed[mq[0].lane*32 +: 32]  = mq[0].data;
      end
      chk("in_ready",   128'(bus.in_ready),   128'(mq.size() < DEPTH));
      chk("count",      128'(count),          128'(mq.size()));
      chk("dest_valid", 128'(bus.dest_valid), 128'(ev));
      chk("dest_data",  128'(bus.dest_data),  128'(ed));
      chk("err_dest",   128'(err_dest),       128'(merr));

      for (int k = 0; k < NUM_DEST; k++) begin
         if (bus.dest_valid[k] && bus.dest_ready[k] && !rst) begin
            dut_out.push_back(bus.dest_data[k*32 +: 32]);
         end
      end

      if (rst) begin
         mq.delete();
         merr = 1'b0;
      end else if (flush) begin
         mq.delete();
      end else begin
         do_pop  = (mq.size() > 0) && bus.dest_ready[mq[0].lane];
         do_push = bus.in_valid && (mq.size() < DEPTH);
         if (do_pop) begin
            void'(mq.pop_front());
         end
         if (do_push) begin
            ent_t e;
            e.data = bus.in_data;
            e.lane = (int'(bus.in_dest) < NUM_DEST) ? int'(bus.in_dest) : 0;
            if (int'(bus.in_dest) >= NUM_DEST) begin
               merr = 1'b1;
            end
            mq.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_dest  = '0;
   endtask

   initial begin
      int accepted;
      rst             = 1'b1;
      flush           = 1'b0;
      bus.dest_ready  = '0;
      idle();
      merr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      step();

      // Single push to lane 2
      bus.dest_ready = 3'b111;
      bus.in_valid = 1'b1; bus.in_dest = 2'd2; bus.in_data = 32'h0000_00AA;
      step();
      idle();
      chk("single_valid", 128'(bus.dest_valid), 128'(3'b100));
      chk("single_lane2", 128'(bus.dest_data[64 +: 32]), 128'(32'hAA));
      step();
      chk("single_drain", 128'(count), 128'(0));

      // Backpressure fill on lane 1
      bus.dest_ready = 3'b000;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.in_dest = 2'd1; bus.in_data = 32'h100 + 32'(i);
         step();
      end
      bus.in_data = 32'h104;
      chk("bp_full_ready", 128'(bus.in_ready), 128'(0));
      chk("bp_full_count", 128'(count), 128'(4));
      step();
      step();
      bus.dest_ready = 3'b010;
      accepted = 0;
      for (int c = 0; c < 20 && accepted == 0; c++) begin
         if (bus.in_ready) accepted = 1;
         step();
      end
      chk("bp_fifth_accepted", 128'(accepted), 128'(1));
      idle();
      for (int c = 0; c < 10; c++) step();
      chk("bp_drained", 128'(count), 128'(0));

      // Head-of-line blocking
      bus.dest_ready = 3'b100;
      bus.in_valid = 1'b1; bus.in_dest = 2'd0; bus.in_data = 32'h11;
      step();
      bus.in_dest = 2'd2; bus.in_data = 32'h22;
      step();
      idle();
      step();
      step();
      chk("hol_blocked", 128'(count), 128'(2));
      bus.dest_ready = 3'b001;
      step();
      chk("hol_next_valid", 128'(bus.dest_valid), 128'(3'b100));
      chk("hol_next_data", 128'(bus.dest_data[64 +: 32]), 128'(32'h22));
      bus.dest_ready = 3'b111;
      step();

      // Illegal tag, sticky through flush
      bus.dest_ready = 3'b000;
      bus.in_valid = 1'b1; bus.in_dest = 2'd3; bus.in_data = 32'h55;
      step();
      idle();
      chk("ill_err", 128'(err_dest), 128'(1));
      chk("ill_lane0_valid", 128'(bus.dest_valid), 128'(3'b001));
      chk("ill_lane0_data", 128'(bus.dest_data[31:0]), 128'(32'h55));
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("ill_err_after_flush", 128'(err_dest), 128'(1));
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("ill_err_after_rst", 128'(err_dest), 128'(0));
      step();

      // Flush collision
      bus.dest_ready = 3'b000;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1; bus.in_dest = 2'(i); bus.in_data = 32'h70 + 32'(i);
         step();
      end
      chk("fc_count3", 128'(count), 128'(3));
      flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h77; bus.in_dest = 2'd1;
      step();
      flush = 1'b0;
      idle();
      chk("fc_count0", 128'(count), 128'(0));
      chk("fc_valid0", 128'(bus.dest_valid), 128'(0));
      step();
      step();

      // Streaming with wrap
      bus.dest_ready = 3'b111;
      dut_out.delete();
      sent.delete();
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.in_dest  = 2'($urandom_range(0, 2));
         bus.in_data  = $urandom;
         sent.push_back(bus.in_data);
         step();
         if (i > 0) chk("wrap_count1", 128'(count), 128'(1));
      end
      idle();
      for (int c = 0; c < 3; c++) step();
      chk("wrap_len", 128'(dut_out.size()), 128'(10));
      for (int i = 0; i < 10 && i < dut_out.size(); i++) begin
         chk("wrap_order", 128'(dut_out[i]), 128'(sent[i]));
      end

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         bus.in_valid   = ($urandom_range(0, 3) != 0);
         bus.in_dest    = 2'($urandom_range(0, 3));
         bus.in_data    = $urandom;
         bus.dest_ready = 3'($urandom);
         flush          = ($urandom_range(0, 24) == 0);
         rst            = ($urandom_range(0, 99) == 0);
         step();
      end
      rst   = 1'b0;
      flush = 1'b0;
      idle();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
